muldiv_unit: RTL and testbench

Parametrised multicycle multiply/divide engine for the multicycle datapath. It replaces the separate `mult` and `div` blocks with one shared shift/add–subtract unit. The unit supports signed and unsigned modes and has a start/done handshake, and it drives the HI/LO register inputs directly. The control unit starts an operation from A/B and waits for `done` before writing HI/LO.

---
 rtl/muldiv_pkg.sv | 17 +
 rtl/muldiv_sign.sv | 56 +++++
 rtl/muldiv_unit.sv | 168 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multicycle multiply/divide engine:
// operation encodings and the sequencer state type.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix,
        StDone
    } state_e;

endpackage

// File: rtl/muldiv_sign.sv
// Sign handling for muldiv_unit: operand magnitudes and result signs at start,
// and conditional negation of the raw unsigned result at FIX.
module muldiv_sign #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH:0]   mag_a,
    output logic [WIDTH:0]   mag_b,
    output logic             neg_lo,
    output logic             neg_hi,
    input  logic             fix_mul,
    input  logic             fix_neg_lo,
    input  logic             fix_neg_hi,
    input  logic [WIDTH-1:0] fix_hi,
    input  logic [WIDTH-1:0] fix_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic           signed_op;
    logic           sign_a;
    logic           sign_b;
    logic [WIDTH:0] ext_a;
    logic [WIDTH:0] ext_b;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_n;

    // One extra bit keeps the magnitude of the most-negative operand intact.
    always_comb begin
        signed_op = ~op[0];
        sign_a    = signed_op & a[WIDTH-1];
        sign_b    = signed_op & b[WIDTH-1];
        ext_a     = {sign_a, a};
        ext_b     = {sign_b, b};
        mag_a     = sign_a ? -ext_a : ext_a;
        mag_b     = sign_b ? -ext_b : ext_b;
        neg_lo    = sign_a ^ sign_b;
        neg_hi    = op[1] ? sign_a : (sign_a ^ sign_b);
    end

    // Products negate as one 2*WIDTH value; quotient and remainder independently.
    always_comb begin
        prod   = {fix_hi, fix_lo};
        prod_n = fix_neg_lo ? -prod : prod;
        if (fix_mul) begin
            res_hi = prod_n[2*WIDTH-1:WIDTH];
            res_lo = prod_n[WIDTH-1:0];
        end else begin
            res_hi = fix_neg_hi ? -fix_hi : fix_hi;
            res_lo = fix_neg_lo ? -fix_lo : fix_lo;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Shared multicycle multiply/divide engine: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with start/done handshake into HI/LO.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic              neg_lo_q, neg_lo_d;
    logic              neg_hi_q, neg_hi_d;
    logic [WIDTH:0]    mag_a_q, mag_a_d;
    logic [WIDTH:0]    mag_b_q, mag_b_d;
    logic [WIDTH:0]    acc_q, acc_d;
    logic [WIDTH-1:0]  mq_q, mq_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              div_zero_q, div_zero_d;

    logic [WIDTH:0]    in_mag_a;
    logic [WIDTH:0]    in_mag_b;
    logic              in_neg_lo;
    logic              in_neg_hi;
    logic [WIDTH-1:0]  res_hi;
    logic [WIDTH-1:0]  res_lo;

    logic [WIDTH:0]    mul_sum;
    logic [WIDTH:0]    div_shift;
    logic [WIDTH:0]    div_sub;
    logic              div_ge;

    muldiv_sign #(
        .WIDTH(WIDTH)
    ) u_sign (
        .a          (a),
        .b          (b),
        .op         (op),
        .mag_a      (in_mag_a),
        .mag_b      (in_mag_b),
        .neg_lo     (in_neg_lo),
        .neg_hi     (in_neg_hi),
        .fix_mul    (~op_q[1]),
        .fix_neg_lo (neg_lo_q),
        .fix_neg_hi (neg_hi_q),
        .fix_hi     (acc_q[WIDTH-1:0]),
        .fix_lo     (mq_q),
        .res_hi     (res_hi),
        .res_lo     (res_lo)
    );

    // Multiply: acc holds the running upper half, mq the multiplier shifting out.
    // Divide: acc holds the partial remainder, mq the dividend shifting out and
    // the quotient shifting in.
    always_comb begin
        mul_sum   = acc_q + (mq_q[0] ? mag_a_q : '0);
        div_shift = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
        div_ge    = (div_shift >= mag_b_q);
        div_sub   = div_shift - mag_b_q;
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        mag_a_d    = mag_a_q;
        mag_b_d    = mag_b_q;
        acc_d      = acc_q;
        mq_d       = mq_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    op_d     = op;
                    mag_a_d  = in_mag_a;
                    mag_b_d  = in_mag_b;
                    neg_lo_d = in_neg_lo;
                    neg_hi_d = in_neg_hi;
                    acc_d    = '0;
                    cnt_d    = '0;
                    mq_d     = op[1] ? in_mag_a[WIDTH-1:0] : in_mag_b[WIDTH-1:0];
                    if (op[1] && (b == '0)) begin
                        state_d    = StDone;
                        div_zero_d = 1'b1;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                if (op_q[1]) begin
                    acc_d = div_ge ? div_sub : div_shift;
                    mq_d  = {mq_q[WIDTH-2:0], div_ge};
                end else begin
                    {acc_d, mq_d} = {mul_sum, mq_q} >> 1;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            op_q       <= OP_MULT;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            mag_a_q    <= '0;
            mag_b_q    <= '0;
            acc_q      <= '0;
            mq_q       <= '0;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            mag_a_q    <= mag_a_d;
            mag_b_q    <= mag_b_d;
            acc_q      <= acc_d;
            mq_q       <= mq_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q == StCalc) || (state_q == StFix);
    assign done     = (state_q == StDone);
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a 32-bit and an 8-bit instance, expected
// results from plain 64-bit arithmetic, checked by a negedge monitor on done.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    typedef longint unsigned u64_t;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start32 = 1'b0, start8 = 1'b0;
    logic [1:0]  op32 = 2'b00, op8 = 2'b00;
    logic [31:0] a32 = '0, b32 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy32, done32, dz32, busy8, done8, dz8;
    logic [31:0] hi32, lo32;
    logic [7:0]  hi8, lo8;

    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t q32[$];
    exp_t q8[$];
    exp_t m32, m8;
    logic [31:0] last_hi32 = '0, last_lo32 = '0, last_hi8 = '0, last_lo8 = '0;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation still running at %0t, required $finish", $time);
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: sign-extend to 64 bits and let native arithmetic do the work.
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                   input int w, input logic [31:0] phi, input logic [31:0] plo);
        exp_t   e;
        u64_t   mask, sb, ux, uy, p, qq, rr;
        longint sx, sy;
        mask = (u64_t'(1) << w) - 1;
        sb   = u64_t'(1) << (w - 1);
        ux   = u64_t'(x) & mask;
        uy   = u64_t'(y) & mask;
        sx   = longint'(ux ^ sb) - longint'(sb);
        sy   = longint'(uy ^ sb) - longint'(sb);
        e.hi = phi;
        e.lo = plo;
        e.dz = 1'b0;
        e.due = 0;
        case (o)
            OP_MULT:  begin p = u64_t'(sx * sy); e.hi = 32'((p >> w) & mask); e.lo = 32'(p & mask); end
            OP_MULTU: begin p = ux * uy;         e.hi = 32'((p >> w) & mask); e.lo = 32'(p & mask); end
            OP_DIV: begin
                if (uy == 0) e.dz = 1'b1;
                else begin
                    qq = u64_t'(sx / sy);
                    rr = u64_t'(sx % sy);
                    e.lo = 32'(qq & mask);
                    e.hi = 32'(rr & mask);
                end
            end
            default: begin
                if (uy == 0) e.dz = 1'b1;
                else begin
                    e.lo = 32'((ux / uy) & mask);
                    e.hi = 32'((ux % uy) & mask);
                end
            end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rnd_opnd(input int w);
        logic [31:0] v;
        int          k;
        k = $urandom_range(0, 9);
        case (k)
            0: v = '0;
            1: v = 32'd1;
            2: v = '1;
            3: v = 32'h1 << (w - 1);
            4: v = (32'h1 << (w - 1)) - 32'd1;
            5: v = 32'($urandom_range(0, 15));
            default: v = $urandom;
        endcase
        if (w != 32) v = v & 32'hFF;
        return v;
    endfunction

    // Waits for the unit to be free, drives start for one cycle and queues the
    // expected result. t is the cycle in which start was presented.
    task automatic issue(input int w, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input bit fixed, input logic [31:0] eh,
                         input logic [31:0] el, input logic edz, output int t);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (((w == 32) ? busy32 : busy8) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if ((w == 32) ? busy32 : busy8) begin
            n_tests++;
            n_fail++;
            $display("FAIL busy_timeout w=%0d: busy still 1 after %0d cycles, required 0", w, n);
        end
        if (fixed) begin
            e.hi = eh; e.lo = el; e.dz = edz;
        end else if (w == 32) begin
            e = model(o, x, y, 32, last_hi32, last_lo32);
        end else begin
            e = model(o, x, y, 8, last_hi8, last_lo8);
        end
        t = cyc;
        e.due = t + (e.dz ? 1 : w + 2);
        if (w == 32) begin
            op32 = o; a32 = x; b32 = y; start32 = 1'b1;
        end else begin
            op8 = o; a8 = x[7:0]; b8 = y[7:0]; start8 = 1'b1;
        end
        @(posedge clk);
        #1;
        start32 = 1'b0;
        start8  = 1'b0;
        if (w == 32) begin
            q32.push_back(e); last_hi32 = e.hi; last_lo32 = e.lo;
        end else begin
            q8.push_back(e); last_hi8 = e.hi; last_lo8 = e.lo;
        end
    endtask

    // Start pulse while busy must be ignored and leave the current operands alone.
    task automatic poke_busy(input int w);
        @(negedge clk);
        if ((w == 32) ? busy32 : busy8) begin
            op32 = 2'($urandom); a32 = $urandom; b32 = $urandom;
            op8 = 2'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
            if (w == 32) start32 = 1'b1; else start8 = 1'b1;
            @(posedge clk);
            #1;
            start32 = 1'b0;
            start8  = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (done32) begin
            if (q32.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done32: got done=1 at cycle %0d, required no done", cyc);
            end else begin
                m32 = q32.pop_front();
                chk("hi32", 64'(hi32), 64'(m32.hi));
                chk("lo32", 64'(lo32), 64'(m32.lo));
                chk("div_zero32", 64'(dz32), 64'(m32.dz));
                chk("done_cycle32", 64'(cyc), 64'(m32.due));
            end
        end
        if (done8) begin
            if (q8.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done8: got done=1 at cycle %0d, required no done", cyc);
            end else begin
                m8 = q8.pop_front();
                chk("hi8", 64'(hi8), 64'(m8.hi[7:0]));
                chk("lo8", 64'(lo8), 64'(m8.lo[7:0]));
                chk("div_zero8", 64'(dz8), 64'(m8.dz));
                chk("done_cycle8", 64'(cyc), 64'(m8.due));
            end
        end
    end

    initial begin
        int t, t1, t2, n;
        logic [1:0] o;

        repeat (3) @(negedge clk);
        chk("rst_busy32", 64'(busy32), 64'd0);
        chk("rst_done32", 64'(done32), 64'd0);
        chk("rst_dz32", 64'(dz32), 64'd0);
        chk("rst_hi32", 64'(hi32), 64'd0);
        chk("rst_lo32", 64'(lo32), 64'd0);
        chk("rst_busy8", 64'(busy8), 64'd0);
        chk("rst_done8", 64'(done8), 64'd0);
        chk("rst_hi8", 64'(hi8), 64'd0);
        chk("rst_lo8", 64'(lo8), 64'd0);
        reset = 1'b0;

        issue(32, OP_MULT,  32'hFFFFFFFD, 32'd5, 1, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, t);
        issue(32, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001, 1'b0, t);
        issue(32, OP_DIV,   32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, t);
        issue(32, OP_DIVU,  32'hFFFFFFF9, 32'd2, 1, 32'h00000001, 32'h7FFFFFFC, 1'b0, t);
        // Divide by zero keeps the previous HI/LO and never raises busy.
        issue(32, OP_DIV,   32'h12345678, 32'd0, 1, 32'h00000001, 32'h7FFFFFFC, 1'b1, t);
        @(negedge clk);
        chk("dz_busy32", 64'(busy32), 64'd0);
        chk("dz_done32", 64'(done32), 64'd1);

        issue(32, OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000, 32'h80000000, 1'b0, t1);
        issue(32, OP_MULTU, 32'h0000BEEF, 32'h00C0FFEE, 0, '0, '0, 1'b0, t2);
        chk("b2b_start_cycle", 64'(t2), 64'(t1 + 34));

        // Reset mid-operation aborts it with no done.
        issue(32, OP_MULT, $urandom, $urandom, 0, '0, '0, 1'b0, t);
        while (cyc < t + 5) @(negedge clk);
        start32 = 1'b1; op32 = OP_DIVU; a32 = $urandom; b32 = 32'd3;
        @(negedge clk);
        start32 = 1'b0;
        while (cyc < t + 10) @(negedge clk);
        reset = 1'b1;
        q32.delete();
        last_hi32 = '0;
        last_lo32 = '0;
        @(negedge clk);
        chk("abort_busy32", 64'(busy32), 64'd0);
        chk("abort_done32", 64'(done32), 64'd0);
        chk("abort_dz32", 64'(dz32), 64'd0);
        chk("abort_hi32", 64'(hi32), 64'd0);
        chk("abort_lo32", 64'(lo32), 64'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_idle32", 64'(busy32), 64'd0);

        for (int i = 0; i < 120; i++) begin
            o = 2'($urandom_range(0, 3));
            issue(32, o, rnd_opnd(32), rnd_opnd(32), 0, '0, '0, 1'b0, t);
            if ($urandom_range(0, 3) == 0) poke_busy(32);
        end

        issue(8, OP_MULTU, 32'hFF, 32'hFF, 1, 32'hFE, 32'h01, 1'b0, t);
        issue(8, OP_DIV, 32'h80, 32'hFF, 1, 32'h00, 32'h80, 1'b0, t);
        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom_range(0, 3));
            issue(8, o, rnd_opnd(8), rnd_opnd(8), 0, '0, '0, 1'b0, t);
            if ($urandom_range(0, 3) == 0) poke_busy(8);
        end

        n = 0;
        while ((q32.size() != 0 || q8.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_q32", 64'(q32.size()), 64'd0);
        chk("drain_q8", 64'(q8.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
